// File: rtl/l1_line_mem_master.sv
// l1_line_mem_master: initiator side of the cache-line memory interface.
// Turns one fill or writeback request into a single BURST_LEN-beat burst and
// returns exactly one completion (done_valid pulse) to the cache controller.
//
// Handshakes:
//  - Request: a transfer happens on a rising edge where req_valid && req_ready.
//    req_ready is high only in IDLE. Request fields are only sampled on that edge.
//  - Memory: mem_read or mem_write stays high with a constant mem_address until
//    the burst ends. Every edge with mem_resp=1 while a command is high moves one
//    beat. mem_resp is ignored when no command is asserted.
//  - Completion: done_valid is a single-cycle pulse and has no ready.
//    done_error and done_rline are qualified by done_valid.
module l1_line_mem_master #(
  parameter int LINE_W    = 128,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [31:0]                 req_addr,
  input  logic [LINE_W-1:0]           req_wline,
  output logic                        done_valid,
  output logic                        done_error,
  output logic [LINE_W-1:0]           done_rline,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [31:0]                 mem_address,
  output logic [LINE_W/BURST_LEN-1:0] mem_wdata,
  output logic [3:0]                  mem_byte_enable,
  input  logic [LINE_W/BURST_LEN-1:0] mem_rdata,
  input  logic                        mem_resp,
  input  logic                        pm_error,
  output logic [1:0]                  fsm_state
);

  localparam int BURST_W = LINE_W / BURST_LEN;
  localparam int BEAT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int WDOG_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int OFF_W   = $clog2(LINE_W / 8);

  localparam logic [31:0]       ADDR_MASK = ~((32'd1 << OFF_W) - 32'd1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(TIMEOUT);
  // The watchdog fires on the edge that brings it up to TIMEOUT, so a stalled
  // burst spends exactly TIMEOUT cycles in READ/WRITE.
  localparam logic [WDOG_W-1:0] WDOG_LAST = (TIMEOUT > 0) ? WDOG_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [31:0]         addr_q;
  logic [LINE_W-1:0]   line_q;
  logic [LINE_W-1:0]   line_next;
  logic [BEAT_W-1:0]   beat;
  logic [WDOG_W-1:0]   wdog;
  logic                err_q;
  logic                busy;
  logic                beat_fire;
  logic                timeout_hit;
  logic                abort;
  logic                finish;

  // Burst-progress conditions shared by the FSM and the datapath.
  always_comb begin
    busy        = (state == S_READ) || (state == S_WRITE);
    beat_fire   = busy && mem_resp;
    timeout_hit = (TIMEOUT != 0) && (wdog >= WDOG_LAST);
    abort       = busy && (pm_error || timeout_hit);
    finish      = abort || (beat_fire && (beat == BEAT_LAST));
  end

  // Line being assembled: a fill beat lands in slice [beat].
  always_comb begin
    line_next = line_q;
    if ((state == S_READ) && mem_resp) begin
      line_next[int'(beat) * BURST_W +: BURST_W] = mem_rdata;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state: IDLE -> READ|WRITE -> DONE -> IDLE.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (req_valid) state_next = req_write ? S_WRITE : S_READ;
      S_READ:  if (finish) state_next = S_DONE;
      S_WRITE: if (finish) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: request latch, beat/watchdog counters, completion line and error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q     <= '0;
      line_q     <= '0;
      beat       <= '0;
      wdog       <= '0;
      err_q      <= 1'b0;
      done_rline <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q <= req_addr & ADDR_MASK;
            line_q <= req_wline;
            beat   <= '0;
            wdog   <= '0;
            err_q  <= 1'b0;
          end
        end
        S_READ, S_WRITE: begin
          line_q <= line_next;
          if (beat_fire) beat <= beat + BEAT_W'(1);
          if ((TIMEOUT != 0) && (wdog != WDOG_MAX)) wdog <= wdog + WDOG_W'(1);
          // An error on the final-beat edge still reports an error, and an
          // aborted fill leaves the previous completion line untouched.
          if (abort) begin
            err_q <= 1'b1;
          end else if (finish && (state == S_READ)) begin
            done_rline <= line_next;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from the registered state so commands drop on the finishing edge.
  always_comb begin
    req_ready       = (state == S_IDLE);
    mem_read        = (state == S_READ);
    mem_write       = (state == S_WRITE);
    done_valid      = (state == S_DONE);
    done_error      = (state == S_DONE) && err_q;
    mem_address     = addr_q;
    mem_wdata       = line_q[int'(beat) * BURST_W +: BURST_W];
    mem_byte_enable = 4'hF;
    fsm_state       = state;
  end

endmodule

// File: tb/tb_l1_line_mem_master.sv
// tb_l1_line_mem_master: directed bench with an expected-value queue for
// completion lines and write beats, immediate-assertion checks and one summary.
module tb_l1_line_mem_master;

  localparam int LINE_W    = 128;
  localparam int BURST_LEN = 4;
  localparam int BURST_W   = LINE_W / BURST_LEN;
  localparam int TIMEOUT   = 16;

  logic                clk;
  logic                rst_n;
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [31:0]         req_addr;
  logic [LINE_W-1:0]   req_wline;
  logic                done_valid;
  logic                done_error;
  logic [LINE_W-1:0]   done_rline;
  logic                mem_read;
  logic                mem_write;
  logic [31:0]         mem_address;
  logic [BURST_W-1:0]  mem_wdata;
  logic [3:0]          mem_byte_enable;
  logic [BURST_W-1:0]  mem_rdata;
  logic                mem_resp;
  logic                pm_error;
  logic [1:0]          fsm_state;

  logic [LINE_W-1:0]   exp_q[$];
  int                  n_checks;
  int                  n_fail;
  logic [LINE_W-1:0]   last_line;

  l1_line_mem_master #(
    .LINE_W(LINE_W), .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wline(req_wline),
    .done_valid(done_valid), .done_error(done_error), .done_rline(done_rline),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .pm_error(pm_error),
    .fsm_state(fsm_state)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                       input logic [LINE_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic [LINE_W-1:0] obs);
    logic [LINE_W-1:0] exp;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    check(tag, obs, exp);
  endtask

  // Driver: present a request in IDLE and let one edge accept it.
  task automatic issue(input logic wr, input logic [31:0] addr,
                       input logic [LINE_W-1:0] wline, input logic hold);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wline = wline;
    check("req_ready_idle", 128'(req_ready), 128'(1));
    step();
    if (!hold) req_valid = 1'b0;
  endtask

  // Driver: one memory beat; write data is compared before the edge that takes it.
  task automatic beat(input logic [BURST_W-1:0] d);
    mem_resp  = 1'b1;
    mem_rdata = d;
    if (mem_write) pop_check("wdata", 128'(mem_wdata));
    step();
    mem_resp  = 1'b0;
    mem_rdata = BURST_W'($urandom);
  endtask

  task automatic gap();
    mem_resp  = 1'b0;
    mem_rdata = BURST_W'($urandom);
    step();
  endtask

  initial begin
    logic [BURST_W-1:0] d[4];
    logic [LINE_W-1:0]  wline;
    logic               steady;
    int                 cnt;

    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wline = '0;
    mem_rdata = '0;
    mem_resp  = 1'b0;
    pm_error  = 1'b0;
    step();
    step();

    // Reset state.
    check("rst_ready", 128'(req_ready), 128'(1));
    check("rst_read", 128'(mem_read), 128'(0));
    check("rst_write", 128'(mem_write), 128'(0));
    check("rst_done", 128'(done_valid), 128'(0));
    check("rst_err", 128'(done_error), 128'(0));
    check("rst_addr", 128'(mem_address), 128'(0));
    check("rst_wdata", 128'(mem_wdata), 128'(0));
    check("rst_rline", done_rline, 128'(0));
    check("rst_state", 128'(fsm_state), 128'(0));
    rst_n = 1'b1;
    step();

    // Fill at 0x104C with a 10-cycle memory delay.
    exp_q.push_back(128'h44444444_33333333_22222222_11111111);
    issue(1'b0, 32'h0000_104C, '0, 1'b0);
    check("t1_read", 128'(mem_read), 128'(1));
    check("t1_write", 128'(mem_write), 128'(0));
    check("t1_ready", 128'(req_ready), 128'(0));
    check("t1_addr", 128'(mem_address), 128'(32'h0000_1040));
    steady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      gap();
      if (mem_address !== 32'h0000_1040 || mem_read !== 1'b1) steady = 1'b0;
    end
    check("t1_steady", 128'(steady), 128'(1));
    beat(32'h11111111);
    beat(32'h22222222);
    beat(32'h33333333);
    check("t1_no_early_done", 128'(done_valid), 128'(0));
    beat(32'h44444444);
    check("t1_done", 128'(done_valid), 128'(1));
    check("t1_err", 128'(done_error), 128'(0));
    check("t1_read_off", 128'(mem_read), 128'(0));
    pop_check("t1_rline", done_rline);
    last_line = 128'h44444444_33333333_22222222_11111111;
    // Stray responses while DONE/IDLE must not disturb anything.
    mem_resp  = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    step();
    check("t1_idle", 128'(req_ready), 128'(1));
    check("t1_done_pulse", 128'(done_valid), 128'(0));
    step();
    mem_resp = 1'b0;
    check("t1_stray_read", 128'(mem_read), 128'(0));

    // Writeback at 0x2000.
    wline = 128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA;
    exp_q.push_back(128'h0000AAAA);
    exp_q.push_back(128'h0000BBBB);
    exp_q.push_back(128'h0000CCCC);
    exp_q.push_back(128'h0000DDDD);
    issue(1'b1, 32'h0000_2000, wline, 1'b0);
    check("t2_write", 128'(mem_write), 128'(1));
    check("t2_read", 128'(mem_read), 128'(0));
    check("t2_addr", 128'(mem_address), 128'(32'h0000_2000));
    check("t2_be", 128'(mem_byte_enable), 128'(4'hF));
    gap();
    beat('0);
    beat('0);
    gap();
    beat('0);
    beat('0);
    check("t2_done", 128'(done_valid), 128'(1));
    check("t2_err", 128'(done_error), 128'(0));
    check("t2_write_off", 128'(mem_write), 128'(0));
    check("t2_rline_kept", done_rline, last_line);
    step();

    // Gapped fill: resp pattern 1,0,1,1,0,1.
    for (int i = 0; i < 4; i++) d[i] = BURST_W'($urandom);
    exp_q.push_back({d[3], d[2], d[1], d[0]});
    issue(1'b0, 32'h0000_3A10 | 32'($urandom_range(0, 15)), '0, 1'b0);
    check("t3_addr", 128'(mem_address), 128'(32'h0000_3A10));
    beat(d[0]);
    gap();
    beat(d[1]);
    beat(d[2]);
    gap();
    check("t3_still_read", 128'(mem_read), 128'(1));
    beat(d[3]);
    check("t3_done", 128'(done_valid), 128'(1));
    check("t3_err", 128'(done_error), 128'(0));
    pop_check("t3_rline", done_rline);
    last_line = {d[3], d[2], d[1], d[0]};
    step();

    // pm_error after the second beat of a fill.
    issue(1'b0, 32'h0000_4000, '0, 1'b0);
    beat(BURST_W'($urandom));
    beat(BURST_W'($urandom));
    pm_error = 1'b1;
    step();
    pm_error = 1'b0;
    check("t4_read_off", 128'(mem_read), 128'(0));
    check("t4_done", 128'(done_valid), 128'(1));
    check("t4_err", 128'(done_error), 128'(1));
    check("t4_rline_kept", done_rline, last_line);
    step();
    check("t4_idle", 128'(req_ready), 128'(1));

    // pm_error on the same edge as the final beat: error wins.
    issue(1'b0, 32'h0000_5000, '0, 1'b0);
    beat(BURST_W'($urandom));
    beat(BURST_W'($urandom));
    beat(BURST_W'($urandom));
    pm_error = 1'b1;
    beat(BURST_W'($urandom));
    pm_error = 1'b0;
    check("t4b_done", 128'(done_valid), 128'(1));
    check("t4b_err", 128'(done_error), 128'(1));
    check("t4b_rline_kept", done_rline, last_line);
    step();

    // Watchdog: fill with no response lasts TIMEOUT cycles in READ.
    issue(1'b0, 32'h0000_6000, '0, 1'b0);
    cnt = 0;
    while (fsm_state == 2'd1 && cnt < 40) begin
      cnt++;
      gap();
    end
    check("t5_cycles", 128'(cnt), 128'(TIMEOUT));
    check("t5_done", 128'(done_valid), 128'(1));
    check("t5_err", 128'(done_error), 128'(1));
    check("t5_read_off", 128'(mem_read), 128'(0));
    step();
    check("t5_ready", 128'(req_ready), 128'(1));

    // Reset in the middle of a writeback (beat 1).
    wline = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 4; i++) exp_q.push_back(128'(wline[i*BURST_W +: BURST_W]));
    issue(1'b1, 32'h0000_7000, wline, 1'b0);
    beat('0);
    rst_n    = 1'b0;
    mem_resp = 1'b1;
    step();
    mem_resp = 1'b0;
    exp_q.delete();
    check("t6_write_off", 128'(mem_write), 128'(0));
    check("t6_no_done", 128'(done_valid), 128'(0));
    check("t6_state", 128'(fsm_state), 128'(0));
    rst_n = 1'b1;
    steady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done_valid !== 1'b0) steady = 1'b0;
    end
    check("t6_no_done_after", 128'(steady), 128'(1));

    // Back-to-back fills with req_valid held high throughout.
    for (int i = 0; i < 4; i++) d[i] = BURST_W'($urandom);
    exp_q.push_back({d[3], d[2], d[1], d[0]});
    issue(1'b0, 32'h0000_8000, '0, 1'b1);
    for (int i = 0; i < 4; i++) beat(d[i]);
    check("t6_done_a", 128'(done_valid), 128'(1));
    check("t6_gap_done", 128'(mem_read), 128'(0));
    check("t6_ready_done", 128'(req_ready), 128'(0));
    pop_check("t6_rline_a", done_rline);
    step();
    check("t6_gap_idle", 128'(mem_read), 128'(0));
    for (int i = 0; i < 4; i++) d[i] = BURST_W'($urandom);
    exp_q.push_back({d[3], d[2], d[1], d[0]});
    issue(1'b0, 32'h0000_9000, '0, 1'b0);
    check("t6_read_b", 128'(mem_read), 128'(1));
    check("t6_addr_b", 128'(mem_address), 128'(32'h0000_9000));
    for (int i = 0; i < 4; i++) beat(d[i]);
    check("t6_done_b", 128'(done_valid), 128'(1));
    pop_check("t6_rline_b", done_rline);
    step();
    check("sb_empty", 128'(exp_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
